// File: rtl/display_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Glyphs are active-low, seg[0]=a .. seg[6]=g.
package display_scan_pkg;

   typedef enum logic {
      SHOW,
      BLANK
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit sources in, board-side segment/anode pins out.
// master = piano control logic, slave = scan controller.
interface display_scan_ctrl_if;

   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] digit_en;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_start;

   modport master (
      output digit0, digit1, digit2, digit3, digit_en,
      input  seg, an, frame_start
   );

   modport slave (
      input  digit0, digit1, digit2, digit3, digit_en,
      output seg, an, frame_start
   );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex to active-low seven-segment glyph lookup.
module hex_to_seg
   import display_scan_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = GLYPH[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with per-frame snapshot.
// Define DISPLAY_SCAN_BLANK_EN for an all-off gap between digits.
module display_scan_ctrl
   import display_scan_pkg::*;
#(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                reset,
   display_scan_ctrl_if.slave  dif
);

   localparam int CMAX = (PRESCALE > BLANK_CYCLES) ?
                         PRESCALE : BLANK_CYCLES;
   localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
`ifdef DISPLAY_SCAN_BLANK_EN
   localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
`endif

   state_t               state_q, state_n;
   logic [1:0]           idx_q, idx_n;
   logic [CW-1:0]        cnt_q, cnt_n;
   logic [3:0][3:0]      snap_q, snap_n;
   logic [3:0]           en_q, en_n;
   logic                 pend_q, pend_n;
   logic [3:0]           an_n;
   logic [6:0]           seg_n;
   logic                 load;
   logic                 wrap;
   logic                 lit;
   logic [6:0]           glyph;

   hex_to_seg u_hex (
      .hex (snap_n[idx_n]),
      .seg (glyph)
   );

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      cnt_n   = cnt_q + 1'b1;
      snap_n  = snap_q;
      en_n    = en_q;
      pend_n  = pend_q;
      wrap    = 1'b0;
      case (state_q)
         SHOW: begin
            if (cnt_q == P_LAST) begin
               cnt_n = '0;
`ifdef DISPLAY_SCAN_BLANK_EN
               state_n = BLANK;
`else
               idx_n = idx_q + 2'd1;
               wrap  = (idx_q == 2'd3);
`endif
            end
         end
         BLANK: begin
`ifdef DISPLAY_SCAN_BLANK_EN
            if (cnt_q == B_LAST) begin
               cnt_n   = '0;
               idx_n   = idx_q + 2'd1;
               wrap    = (idx_q == 2'd3);
               state_n = SHOW;
            end
`else
            state_n = SHOW;
`endif
         end
         default: state_n = SHOW;
      endcase

      // Reload on frame wrap, or on the first edge after reset.
      load = wrap || pend_q;
      if (load) begin
         snap_n = {dif.digit3, dif.digit2,
                   dif.digit1, dif.digit0};
         en_n   = dif.digit_en;
         pend_n = 1'b0;
      end

      lit   = (state_n == SHOW) && en_n[idx_n];
      an_n  = lit ? ~(4'b0001 << idx_n) : AN_OFF;
      seg_n = lit ? glyph : SEG_OFF;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= SHOW;
         idx_q           <= '0;
         cnt_q           <= '0;
         snap_q          <= '0;
         en_q            <= '0;
         pend_q          <= 1'b1;
         dif.an          <= AN_OFF;
         dif.seg         <= SEG_OFF;
         dif.frame_start <= 1'b0;
      end else begin
         state_q         <= state_n;
         idx_q           <= idx_n;
         cnt_q           <= cnt_n;
         snap_q          <= snap_n;
         en_q            <= en_n;
         pend_q          <= pend_n;
         dif.an          <= an_n;
         dif.seg         <= seg_n;
         dif.frame_start <= load;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (PRESCALE=4, BLANK_CYCLES=2).
module tb_display_scan_ctrl;

   localparam int P = 4;
   localparam int B = 2;
`ifdef DISPLAY_SCAN_BLANK_EN
   localparam int L = P + B;
`else
   localparam int L = P;
`endif
   localparam int FR = 4 * L;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   display_scan_ctrl_if dif ();

   display_scan_ctrl #(
      .PRESCALE     (P),
      .BLANK_CYCLES (B)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .dif   (dif.slave)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       fs;
   } exp_t;

   typedef struct {
      logic [3:0] d;
      logic [6:0] seg;
   } vec_t;

   exp_t       q[$];
   vec_t       vt[16];
   int         checks = 0;
   int         failures = 0;
   int         k = 0;
   logic [3:0] m_snap[4];
   logic [3:0] m_en = '0;
   int         bad_an = 0;

   task automatic chk(input string nm, input int act,
                      input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, req);
      end
   endtask

   function automatic int m_idx();
      return (k / L) % 4;
   endfunction

   // Reference model: position in the frame is a pure function of
   // the number of non-reset edges since reset.
   task automatic step();
      exp_t e;
      exp_t g;
      int   ph;
      int   id;
      bit   lit;
      if (reset) begin
         k = 0;
         e = '{an: 4'hF, seg: 7'h7F, fs: 1'b0};
      end else begin
         k++;
         e.fs = (k == 1) || (k % FR == 0);
         if (e.fs) begin
            m_snap[0] = dif.digit0;
            m_snap[1] = dif.digit1;
            m_snap[2] = dif.digit2;
            m_snap[3] = dif.digit3;
            m_en = dif.digit_en;
         end
         ph  = k % L;
         id  = (k / L) % 4;
         lit = (ph < P) && m_en[id];
         e.an  = lit ? ~(4'b0001 << id) : 4'hF;
         e.seg = lit ? vt[m_snap[id]].seg : 7'h7F;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      g = q.pop_front();
      chk("an", int'(dif.an), int'(g.an));
      chk("seg", int'(dif.seg), int'(g.seg));
      chk("frame_start", int'(dif.frame_start), int'(g.fs));
      if ($countones(~dif.an) > 1) bad_an++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < FR + 2; i++) begin
         step();
         if (dif.frame_start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idx(input int id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < FR + 2; i++) begin
         step();
         if (m_idx() == id && (k % L) == 1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      bit seen;
      int v;
      logic [6:0] gl [16] = '{
         7'h40, 7'h79, 7'h24, 7'h30,
         7'h19, 7'h12, 7'h02, 7'h78,
         7'h00, 7'h10, 7'h08, 7'h03,
         7'h46, 7'h21, 7'h06, 7'h0E
      };
      for (int i = 0; i < 16; i++) begin
         vt[i].d   = 4'(i);
         vt[i].seg = gl[i];
      end
      for (int i = 0; i < 4; i++) m_snap[i] = '0;

      dif.digit0   = 4'd1;
      dif.digit1   = 4'd2;
      dif.digit2   = 4'd3;
      dif.digit3   = 4'd4;
      dif.digit_en = 4'hF;

      // Reset state
      reset = 1'b1;
      run(3);
      chk("reset_an", int'(dif.an), 'hF);
      chk("reset_seg", int'(dif.seg), 'h7F);

      // Basic scan: first edge after release lights digit0
      reset = 1'b0;
      step();
      chk("first_lit_an", int'(dif.an), 'hE);
      chk("first_lit_seg", int'(dif.seg), 'h79);
      chk("first_fs", int'(dif.frame_start), 1);
      run(3 * FR);

      // Snapshot: change digit0 mid-frame
      wait_idx(2, ok);
      chk("wait_idx2", int'(ok), 1);
      dif.digit0 = 4'd7;
      run(1);
      wait_fs(ok);
      chk("snap_fs", int'(ok), 1);
      chk("snap_seg", int'(dif.seg), 'h78);
      chk("snap_an", int'(dif.an), 'hE);
      run(FR);

      // Enable mask
      dif.digit_en = 4'b0101;
      wait_fs(ok);
      chk("mask_fs", int'(ok), 1);
      run(2 * FR);

      // All disabled: scan continues, frame_start still pulses
      dif.digit_en = 4'b0000;
      wait_fs(ok);
      wait_fs(ok);
      chk("all_off_fs", int'(ok), 1);
      chk("all_off_an", int'(dif.an), 'hF);
      dif.digit_en = 4'hF;
      run(FR);

      // Reset mid-slot
      wait_idx(2, ok);
      chk("wait_idx2_rst", int'(ok), 1);
      reset = 1'b1;
      step();
      chk("rst_mid_an", int'(dif.an), 'hF);
      chk("rst_mid_seg", int'(dif.seg), 'h7F);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (!seen && dif.an == 4'hE && dif.frame_start)
            seen = 1'b1;
      end
      chk("rst_relit", int'(seen), 1);
      run(FR);

      // Full decode sweep through table
      for (int i = 0; i < 16; i++) begin
         v = (i * 7) % 16;
         dif.digit0 = vt[v].d;
         wait_fs(ok);
         chk("dec_fs", int'(ok), 1);
         chk($sformatf("dec_seg_%0h", v),
             int'(dif.seg), int'(vt[v].seg));
      end
      run(FR);

      chk("an_onehot", bad_an, 0);
      chk("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=done");
      $fatal(1, "timeout");
   end

endmodule
